// File: rtl/mp3_mailbox_sequencer.sv
// Mailbox command sequencer: polls word 0 of the CPU mailbox RAM, fetches the
// three argument words, hands the command downstream and writes DONE/status back.
//
// state     | meaning
// S_IDLE    | counting down to the next poll of word 0
// S_RD0     | read of word 0 on the bus
// S_CHK0    | word 0 data returned; test GO
// S_ARG     | pipelined fetch of words 1..3 (4 cycles, phase in arg_ph)
// S_ISSUE   | cmd_valid held until cmd_ready
// S_WAIT    | waiting for cmd_done or timeout
// S_WB      | write DONE/status/opcode back to word 0
module mp3_mailbox_sequencer #(
  parameter int POLL_INTERVAL  = 64,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 20
) (
  input  logic        clk,
  input  logic        reset,
  output logic [1:0]  mem_address,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  output logic        mem_clken,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_opcode,
  output logic [31:0] cmd_arg0,
  output logic [31:0] cmd_arg1,
  output logic [31:0] cmd_arg2,
  input  logic        cmd_done,
  input  logic [7:0]  cmd_status,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_CHK0, S_ARG, S_ISSUE, S_WAIT, S_WB
  } state_t;

  localparam logic [CNT_W-1:0] POLL_RELOAD = CNT_W'(POLL_INTERVAL - 1);
  localparam logic [CNT_W-1:0] TO_RELOAD   = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       arg_ph, arg_ph_n;
  logic [7:0]       status;
  logic             timeout_hit;

  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign busy           = (state != S_IDLE);
  assign timeout_hit    = (TIMEOUT_CYCLES != 0) && (cnt == '0);
  assign mem_writedata  = (state == S_WB) ?
                          {1'b0, 1'b1, 6'b0, status, 8'b0, cmd_opcode} : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= POLL_RELOAD;
      arg_ph <= 2'd0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      arg_ph <= arg_ph_n;
    end
  end

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    arg_ph_n       = arg_ph;
    mem_address    = 2'd0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    cmd_valid      = 1'b0;
    case (state)
      S_IDLE: begin
        if (cnt == '0) state_n = S_RD0;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      S_RD0: begin
        mem_chipselect = 1'b1;
        state_n        = S_CHK0;
      end
      S_CHK0: begin
        if (mem_readdata[31]) begin
          state_n  = S_ARG;
          arg_ph_n = 2'd0;
        end else begin
          state_n = S_IDLE;
          cnt_n   = POLL_RELOAD;
        end
      end
      S_ARG: begin
        // phases 0..2 issue words 1..3; phase 3 only captures the last word
        if (arg_ph != 2'd3) begin
          mem_chipselect = 1'b1;
          mem_address    = arg_ph + 2'd1;
        end else begin
          state_n = S_ISSUE;
        end
        arg_ph_n = arg_ph + 2'd1;
      end
      S_ISSUE: begin
        cmd_valid = 1'b1;
        if (cmd_ready) begin
          state_n = S_WAIT;
          cnt_n   = TO_RELOAD;
        end
      end
      S_WAIT: begin
        if (cmd_done || timeout_hit) state_n = S_WB;
        else if (cnt != '0)          cnt_n   = cnt - CNT_W'(1);
      end
      S_WB: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        state_n        = S_IDLE;
        cnt_n          = POLL_RELOAD;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_opcode <= 8'h0;
      cmd_arg0   <= 32'h0;
      cmd_arg1   <= 32'h0;
      cmd_arg2   <= 32'h0;
      status     <= 8'h0;
    end else begin
      case (state)
        S_CHK0: if (mem_readdata[31]) cmd_opcode <= mem_readdata[7:0];
        S_ARG: begin
          case (arg_ph)
            2'd1:    cmd_arg0 <= mem_readdata;
            2'd2:    cmd_arg1 <= mem_readdata;
            2'd3:    cmd_arg2 <= mem_readdata;
            default: ;
          endcase
        end
        // a real completion beats a simultaneous timeout
        S_WAIT: begin
          if (cmd_done)         status <= cmd_status;
          else if (timeout_hit) status <= 8'hFF;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mp3_mailbox_sequencer.sv
// Bench for mp3_mailbox_sequencer: mailbox RAM model, directed command
// scenarios and a transaction-timeline model checked every cycle.
module tb_mp3_mailbox_sequencer;
  localparam int P = 4;
  localparam int T = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata, mem_readdata;
  logic        cmd_valid, cmd_ready, cmd_done, busy;
  logic [7:0]  cmd_opcode, cmd_status;
  logic [31:0] cmd_arg0, cmd_arg1, cmd_arg2;

  mp3_mailbox_sequencer #(.POLL_INTERVAL(P), .TIMEOUT_CYCLES(T), .CNT_W(20)) dut (
    .clk(clk), .reset(reset),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_clken(mem_clken),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_arg0(cmd_arg0), .cmd_arg1(cmd_arg1), .cmd_arg2(cmd_arg2),
    .cmd_done(cmd_done), .cmd_status(cmd_status), .busy(busy)
  );

  always #5 clk = ~clk;

  // mailbox RAM: software port (sw_*) plus the block's s2 port, 1-cycle read
  logic [31:0] mem [4];
  logic        sw_we = 1'b0;
  logic [1:0]  sw_addr = 2'd0;
  logic [31:0] sw_data = 32'h0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sw_we) mem[sw_addr] <= sw_data;
    if (mem_chipselect) begin
      if (mem_write) mem[mem_address] <= mem_writedata;
      else           mem_readdata     <= mem[mem_address];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic expired(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Transaction-timeline model: c counts cycles since reset release.
  bit          started = 1'b0, rst_prev = 1'b0, txn = 1'b0, accepted = 1'b0;
  int          c = 0, rd0_t = 0, base = 0, acc_t = -1, wb_t = -1;
  logic [31:0] snap [4];
  logic [7:0]  m_status = 8'h0;
  logic        exp_cs, exp_we, exp_valid, exp_busy;
  logic [1:0]  exp_addr;
  int          n_acc = 0, last_rd0 = -1;

  always @(negedge clk) begin
    if (rst_prev) begin
      started = 1'b1; c = 0; rd0_t = P; txn = 1'b0;
      accepted = 1'b0; acc_t = -1; wb_t = -1;
    end
    if (started) begin
      exp_cs = 1'b0; exp_we = 1'b0; exp_addr = 2'd0;
      if (!txn && c == rd0_t) exp_cs = 1'b1;
      if (txn && c >= base + 2 && c <= base + 4) begin
        exp_cs   = 1'b1;
        exp_addr = 2'(c - base - 1);
      end
      if (txn && c == wb_t) begin exp_cs = 1'b1; exp_we = 1'b1; end
      exp_valid = txn && c >= base + 6 && !accepted;
      exp_busy  = txn || c >= rd0_t;

      check("chipselect", 32'(mem_chipselect), 32'(exp_cs));
      check("write",      32'(mem_write),      32'(exp_we));
      check("cmd_valid",  32'(cmd_valid),      32'(exp_valid));
      check("busy",       32'(busy),           32'(exp_busy));
      check("byteenable", 32'(mem_byteenable), 32'hF);
      check("clken",      32'(mem_clken),      32'h1);
      if (exp_cs) check("address", 32'(mem_address), 32'(exp_addr));
      if (exp_we) check("writedata", mem_writedata, {2'b01, 6'b0, m_status, 8'b0, snap[0][7:0]});
      if (exp_valid) begin
        check("opcode", 32'(cmd_opcode), 32'(snap[0][7:0]));
        check("arg0", cmd_arg0, snap[1]);
        check("arg1", cmd_arg1, snap[2]);
        check("arg2", cmd_arg2, snap[3]);
      end

      if (mem_chipselect && !mem_write && mem_address == 2'd0) last_rd0 = cyc;
      if (cmd_valid && cmd_ready) n_acc++;

      if (!txn && c == rd0_t) for (int i = 0; i < 4; i++) snap[i] = mem[i];
      if (!txn && c == rd0_t + 1) begin
        if (snap[0][31]) begin
          txn = 1'b1; base = rd0_t; accepted = 1'b0; acc_t = -1; wb_t = -1;
        end else begin
          rd0_t = rd0_t + P + 2;
        end
      end
      if (exp_valid && cmd_ready) begin accepted = 1'b1; acc_t = c; end
      if (txn && accepted && wb_t < 0 && c > acc_t) begin
        if (cmd_done) begin
          wb_t = c + 1; m_status = cmd_status;
        end else if (c == acc_t + T) begin
          wb_t = c + 1; m_status = 8'hFF;
        end
      end
      if (txn && c == wb_t) begin txn = 1'b0; rd0_t = c + 1 + P; end
      c++;
    end
    rst_prev = reset;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sw_write(input logic [1:0] a, input logic [31:0] d);
    sw_we = 1'b1; sw_addr = a; sw_data = d;
    tick();
    sw_we = 1'b0;
  endtask

  task automatic wait_rd0(output int t);
    t = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_chipselect && !mem_write && mem_address == 2'd0) begin t = cyc; break; end
    end
    if (t < 0) expired("wait_rd0");
  endtask

  task automatic wait_valid(output int t);
    t = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cmd_valid) begin t = cyc; break; end
    end
    if (t < 0) expired("wait_valid");
  endtask

  task automatic wait_write(output int t);
    t = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_write) begin t = cyc; break; end
    end
    if (t < 0) expired("wait_write");
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input int rdy_dly, input int done_dly,
                         input logic [7:0] st, input bit early,
                         output int rise_c, output int acc_c, output int wb_c);
    sw_write(2'd1, a0);
    sw_write(2'd2, a1);
    sw_write(2'd3, a2);
    cmd_ready  = (rdy_dly == 0);
    cmd_status = st;
    sw_write(2'd0, {1'b1, 23'b0, op});
    wait_valid(rise_c);
    check("issue_latency", 32'(rise_c - last_rd0 - 1), 32'd5);
    acc_c = rise_c;
    for (int i = 1; i <= rdy_dly; i++) begin
      tick();
      cmd_done  = early && (i == 1);
      cmd_ready = (i == rdy_dly);
      acc_c     = cyc;
    end
    for (int i = 1; i <= done_dly; i++) begin
      tick();
      cmd_ready = 1'b0;
      cmd_done  = (i == done_dly);
    end
    tick();
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    wait_write(wb_c);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, t0, t1, rise, acc, wb, acc_before;
    cmd_ready = 1'b0; cmd_done = 1'b0; cmd_status = 8'h0;
    tick();
    for (int i = 0; i < 4; i++) sw_write(2'(i), 32'h0);

    // 1: idle polling with word 0 clear
    reset = 1'b0;
    rel = cyc;
    wait_rd0(t0);
    check("first_poll", 32'(t0 - rel), 32'd4);
    wait_rd0(t1);
    check("poll_period", 32'(t1 - t0), 32'd6);
    check("no_transfer_idle", 32'(n_acc), 32'd0);
    tick();

    // 2: basic command, done three cycles after acceptance
    run_cmd(8'h12, 32'hA, 32'hB, 32'hC, 0, 3, 8'h05, 1'b0, rise, acc, wb);
    check("t2_word0", mem[0], 32'h4005_0012);
    check("t2_wb_delay", 32'(wb - acc), 32'd4);

    // 3: ready held low for 7 cycles
    acc_before = n_acc;
    run_cmd(8'h21, 32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 7, 2, 8'h11, 1'b0, rise, acc, wb);
    check("t3_one_transfer", 32'(n_acc - acc_before), 32'd1);
    check("t3_accept_delay", 32'(acc - rise), 32'd7);
    check("t3_word0", mem[0], 32'h4011_0021);

    // 4: timeout, then cmd_done in the expiry cycle
    run_cmd(8'h33, 32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFFF, 0, 0, 8'h00, 1'b0, rise, acc, wb);
    check("t4_timeout_word0", mem[0], 32'h40FF_0033);
    check("t4_wait_cycles", 32'(wb - acc - 1), 32'd10);
    run_cmd(8'h34, 32'h5, 32'h6, 32'h7, 0, 10, 8'h5A, 1'b0, rise, acc, wb);
    check("t4_expiry_done_word0", mem[0], 32'h405A_0034);

    // 6: cmd_done pulsed while cmd_valid waits for ready
    run_cmd(8'h66, 32'h0123_4567, 32'h89AB_CDEF, 32'h0F0F_0F0F, 3, 2, 8'h77, 1'b1, rise, acc, wb);
    check("t6_word0", mem[0], 32'h4077_0066);
    check("t6_wb_delay", 32'(wb - acc), 32'd3);

    // 5: reset while waiting for completion
    sw_write(2'd1, 32'h9);
    sw_write(2'd2, 32'h8);
    sw_write(2'd3, 32'h7);
    cmd_ready = 1'b1;
    sw_write(2'd0, 32'h8000_0055);
    wait_valid(rise);
    tick();
    cmd_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("t5_busy_after_reset", 32'(busy), 32'd0);
    check("t5_word0_kept", mem[0], 32'h8000_0055);
    sw_write(2'd0, 32'h0);
    reset = 1'b0;
    rel = cyc;
    wait_rd0(t0);
    check("t5_repoll", 32'(t0 - rel), 32'd4);
    repeat (20) tick();
    check("t5_no_writeback", mem[0], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mp3_mailbox_sequencer.md
Name: mp3_mailbox_sequencer

Overview:
- Avalon-MM master that sits directly on the s2 side of the 4-word (32-bit) on-chip mailbox RAM in mp3player_soc.
- Polls mailbox word 0 for a CPU-posted command, fetches the three argument words and hands the command to the audio/decoder control path with a valid/ready handshake.
- Waits for completion, then writes a status word back to word 0 so software sees DONE.
- Offloads command dispatch from the Nios CPU.

Parameters:
- POLL_INTERVAL, 64, idle cycles between successive reads of word 0 (≥1).
- TIMEOUT_CYCLES, 65535, max cycles in WAIT_DONE before forced completion; 0 disables the timeout.
- CNT_W, 20, width of the shared poll/timeout counter; must hold max(POLL_INTERVAL, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mem_address  out  2  mailbox word index.
- mem_chipselect  out  1  access strobe.
- mem_write  out  1  write strobe; read when 0 with chipselect=1.
- mem_byteenable  out  4  always 4'b1111.
- mem_writedata  out  32  write-back status word.
- mem_readdata  in  32  RAM read data, valid the cycle after the address is presented.
- mem_clken  out  1  tied 1.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  downstream accepts the command.
- cmd_opcode  out  8  word0[7:0].
- cmd_arg0  out  32  word 1.
- cmd_arg1  out  32  word 2.
- cmd_arg2  out  32  word 3.
- cmd_done  in  1  single-cycle completion pulse from downstream.
- cmd_status  in  8  result code, sampled with cmd_done.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- Word 0 format: [31] GO (set by software), [30] DONE (set by block), [23:16] STATUS, [7:0] OPCODE. All other bits are written as 0 on write-back.
- Reset: state=IDLE and counter=POLL_INTERVAL-1. All outputs are 0 except mem_byteenable=4'hF and mem_clken=1. Opcode/argument registers clear to 0.
- Reset mid-operation aborts immediately. No write-back occurs, and word 0 is left untouched.
- RAM read latency is exactly 1 cycle. The block is the sole s2 master, so there is no wait-request.
- IDLE: counter decrements each cycle; at 0 go to RD0. The first read of word 0 therefore issues POLL_INTERVAL cycles after reset deasserts.
- RD0: drive address=0, chipselect=1, write=0 for 1 cycle, then go to CHK0.
- CHK0: sample readdata.
  - GO=0 → IDLE and reload counter. Idle poll period is POLL_INTERVAL+2 cycles.
  - GO=1 → latch opcode; go to ARG with address 1 driven.
- ARG: pipelined fetch.
  - Cycle a: issue addr1.
  - Cycle b: capture arg0, issue addr2.
  - Cycle c: capture arg1, issue addr3.
  - Cycle d: capture arg2.
  - Then ISSUE. Total 4 cycles.
- ISSUE: cmd_valid=1 with opcode and arguments stable until cmd_valid&cmd_ready. The handshake completes in that same cycle; next state is WAIT_DONE, cmd_valid drops, and the counter loads TIMEOUT_CYCLES-1.
- WAIT_DONE:
  - cmd_done=1 → latch cmd_status, go to WB.
  - Counter reaches 0 with TIMEOUT_CYCLES≠0 → status=8'hFF, go to WB.
  - cmd_done in the same cycle as timeout expiry: cmd_done wins.
  - cmd_done outside WAIT_DONE is ignored, including in the ISSUE acceptance cycle.
- WB: 1 cycle with address=0, chipselect=1, write=1, writedata={1'b0,1'b1,6'b0,status,8'b0,opcode}. Then IDLE with counter reloaded.
- Back-to-back commands: software must clear DONE and set GO again; the block never re-reads word 0 before the next poll.
- mem_chipselect is high only in RD0, the ARG issue cycles and WB.

Test Plan:
1. Reset, word0=0, POLL_INTERVAL=4 → all outputs idle. A word-0 read occurs 4 cycles after reset release, then every 6 cycles. cmd_valid stays 0 and no writes occur.
2. Preload word0=32'h8000_0012, words1..3=A,B,C → cmd_valid rises 5 cycles after the CHK0 read with opcode=8'h12, arg0=A, arg1=B, arg2=C. With ready=1 and cmd_done=1 plus status=8'h05 three cycles later, the block writes word0=32'h4005_0012.
3. Hold cmd_ready=0 for 7 cycles → cmd_valid and all fields stay stable. cmd_valid falls the cycle after the ready handshake, and exactly one transfer occurs.
4. TIMEOUT_CYCLES=10 with cmd_done never asserted → word0 is written as 32'h40FF_00xx exactly 10 cycles after acceptance. Repeat with cmd_done in the expiry cycle → the real status is written.
5. Assert reset in WAIT_DONE → next cycle busy=0, no write to word 0, and polling restarts after POLL_INTERVAL cycles.
6. Pulse cmd_done during ISSUE before ready → the pulse is ignored and the block waits for a later cmd_done.
